// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and defaults for the repeated-addition multiplier
// controller.
//   state_e      - controller state encoding (3 bits, fixed values)
//   CW_DEF       - default iteration counter / B counter width
//   MAX_ITER_DEF - default watchdog limit on RUN iterations
package mul_seq_pkg;

  localparam int          CW_DEF       = 16;
  localparam int unsigned MAX_ITER_DEF = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: command/status and datapath-strobe bundle of the multiplier
// controller.
//   start, abort, res_ack - requests from the consumer
//   eqz                   - B counter == 0, from the datapath comparator
//   ldA, ldB, clrP, ldP, decB - datapath strobes from the controller
//   busy, done, err, iter_cnt - status from the controller
// Modports:
//   master - the controller (drives strobes and status)
//   slave  - the environment: consumer plus datapath
interface mul_seq_ctrl_if #(
  parameter int CW = 16
);

  logic          start;
  logic          abort;
  logic          res_ack;
  logic          eqz;
  logic          ldA;
  logic          ldB;
  logic          clrP;
  logic          ldP;
  logic          decB;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] iter_cnt;

  modport master (
    input  start, abort, res_ack, eqz,
    output ldA, ldB, clrP, ldP, decB, busy, done, err, iter_cnt
  );

  modport slave (
    output start, abort, res_ack, eqz,
    input  ldA, ldB, clrP, ldP, decB, busy, done, err, iter_cnt
  );

endinterface

// File: rtl/mul_seq_ctrl_iter_wdog.sv
// iter_wdog: iteration counter with a registered limit compare.
//   clk, rst_n - clock, synchronous active-low reset
//   clr        - clear the count to 0 (takes priority over inc)
//   inc        - add one to the count
//   cnt        - current iteration count
//   at_max     - registered flag, 1 exactly when cnt == MAX_ITER
module iter_wdog #(
  parameter int          CW       = 16,
  parameter int unsigned MAX_ITER = 32'h0000_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_ITER);

  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  // at_max is computed from the value being written so it tracks cnt with no
  // extra cycle of lag, while keeping the compare off the FSM's decode path.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement or process order.
    if (!rst_n) begin
      cnt    <= '0;
      at_max <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      at_max <= (MAX_C == '0);
    end else if (inc) begin
      cnt    <= cnt_inc;
      at_max <= (cnt_inc == MAX_C);
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: controller FSM for a repeated-addition multiplier datapath.
// Loads A then B from the shared bus, clears P with the B load, then runs
// P <= P + A while decrementing B until B == 0. A watchdog ends the loop in
// ERR after MAX_ITER iterations without reaching B == 0.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - mul_seq_ctrl_if.master: requests in, datapath strobes and status out
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int          CW       = CW_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mul_seq_ctrl_if.master        bus
);

  state_e state, state_nxt;
  logic   cnt_clr, cnt_inc, at_max;

  iter_wdog #(
    .CW       (CW),
    .MAX_ITER (MAX_ITER)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (bus.iter_cnt),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    bus.ldA   = 1'b0;
    bus.ldB   = 1'b0;
    bus.clrP  = 1'b0;
    bus.ldP   = 1'b0;
    bus.decB  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    // Reset and abort suppress every strobe in the cycle they are seen, so a
    // cancelled operation leaves the datapath exactly as it was.
    if (!rst_n || bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   if (bus.start) state_nxt = ST_LOAD_A;
        ST_LOAD_A: begin
          bus.ldA   = 1'b1;
          state_nxt = ST_LOAD_B;
        end
        ST_LOAD_B: begin
          bus.ldB   = 1'b1;
          bus.clrP  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_RUN;
        end
        ST_RUN: begin
          // eqz wins over the watchdog so B == MAX_ITER still finishes in DONE.
          if (bus.eqz) begin
            state_nxt = ST_DONE;
          end else if (at_max) begin
            state_nxt = ST_ERR;
          end else begin
            bus.ldP  = 1'b1;
            bus.decB = 1'b1;
            cnt_inc  = 1'b1;
          end
        end
        ST_DONE:   if (bus.res_ack) state_nxt = ST_IDLE;
        ST_ERR:    if (bus.res_ack) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ST_LOAD_A) || (state == ST_LOAD_B) || (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.err  = (state == ST_ERR);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: scoreboard bench for mul_seq_ctrl with a small watchdog
// limit so both completion and watchdog paths are reachable. A behavioural
// datapath (A, B, P registers) follows the DUT strobes; expected results come
// from plain arithmetic on the operands.
module tb_mul_seq_ctrl;

  localparam int CW = 16;
  localparam int M  = 8;

  typedef struct {
    bit            is_err;
    logic [CW-1:0] p;
    logic [CW-1:0] iter;
    int            lat;
  } resp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] opa   = '0;
  logic [CW-1:0] opb   = '0;
  logic [CW-1:0] data_in;
  logic [CW-1:0] a_reg = '0;
  logic [CW-1:0] b_reg = '0;
  logic [CW-1:0] p_reg = '0;

  resp_t sb_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl_if #(.CW(CW)) bus ();

  mul_seq_ctrl #(.CW(CW), .MAX_ITER(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural datapath driven by the controller's strobes.
  assign data_in = bus.ldA ? opa : opb;
  assign bus.eqz = (b_reg == '0);

  always @(posedge clk) begin
    if (bus.ldA) a_reg <= data_in;
    if (bus.ldB) b_reg <= data_in;
    else if (bus.decB) b_reg <= b_reg - 1'b1;
    if (bus.clrP) p_reg <= '0;
    else if (bus.ldP) p_reg <= p_reg + a_reg;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle strobe rules, held-result rules, and scoreboard pops
  // on the first cycle of each done/err.
  initial begin
    int    cyc       = 0;
    bit    prev_out  = 1'b0;
    bit    prev_hold = 1'b0;
    logic [1:0]    prev_de   = '0;
    logic [CW-1:0] prev_iter = '0;
    resp_t r;
    forever begin
      @(negedge clk);
      check("ld_exclusive", 32'($countones({bus.ldA, bus.ldB, bus.ldP}) > 1), 0);
      check("decB_with_ldP", bus.decB, bus.ldP);
      check("clrP_with_ldB", bus.clrP, bus.ldB);
      if (bus.ldA) cyc = 0;
      else cyc++;
      if (prev_hold) begin
        check("result_held", {bus.done, bus.err}, prev_de);
        check("iter_held", bus.iter_cnt, prev_iter);
      end
      if ((bus.done || bus.err) && !prev_out) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          r = sb_q.pop_front();
          check("kind_err", bus.err, r.is_err);
          check("kind_done", bus.done, !r.is_err);
          check("product", p_reg, r.p);
          check("iter_cnt", bus.iter_cnt, r.iter);
          check("latency", cyc, r.lat);
        end
      end
      prev_out  = bus.done || bus.err;
      prev_hold = (bus.done || bus.err) && !bus.res_ack && !bus.abort && rst_n;
      prev_de   = {bus.done, bus.err};
      prev_iter = bus.iter_cnt;
    end
  end

  function automatic resp_t model(input logic [CW-1:0] a, input logic [CW-1:0] b);
    resp_t r;
    int    n;
    n        = (b <= M) ? int'(b) : M;
    r.is_err = (b > M);
    r.p      = CW'(int'(a) * n);
    r.iter   = CW'(n);
    r.lat    = n + 3;
    return r;
  endfunction

  task automatic launch(input logic [CW-1:0] a, input logic [CW-1:0] b, input bit push);
    opa = a;
    opb = b;
    @(posedge clk); #1;
    bus.start = 1'b1;
    if (push) sb_q.push_back(model(a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int k = 0;
    while (!(bus.done || bus.err) && k < 200) begin
      @(negedge clk);
      k++;
    end
    ok = (k < 200);
    if (!ok) check("result_timeout", 1, 0);
  endtask

  task automatic finish_op(input int ack_dly, input logic [CW-1:0] exp_iter);
    bit ok;
    wait_out(ok);
    if (!ok) return;
    repeat (ack_dly) @(negedge clk);
    @(posedge clk); #1;
    bus.res_ack = 1'b1;
    @(posedge clk); #1;
    bus.res_ack = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);
    check("idle_err", bus.err, 0);
    check("idle_iter_hold", bus.iter_cnt, exp_iter);
  endtask

  task automatic run_op(input logic [CW-1:0] a, input logic [CW-1:0] b, input int ack_dly);
    launch(a, b, 1'b1);
    finish_op(ack_dly, (b <= M) ? b : CW'(M));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_strobes"}, {bus.ldA, bus.ldB, bus.clrP, bus.ldP, bus.decB}, 0);
  endtask

  initial begin
    bit ok;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.res_ack = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err, 0);
    check("reset_iter", bus.iter_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic products, B = 0, watchdog boundary either side of MAX_ITER.
    run_op(16'd5, 16'd3, 2);
    run_op(16'd7, 16'd0, 1);
    run_op(16'd9, 16'd10, 1);
    run_op(16'd6, 16'd8, 0);
    run_op(16'd11, 16'd9, 3);

    // Abort in the second RUN cycle.
    launch(16'd4, 16'd10, 1'b0);
    repeat (3) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(negedge clk);
    check_quiet("abort");
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_err", bus.err, 0);
    check("abort_iter", bus.iter_cnt, 1);
    run_op(16'd4, 16'd2, 0);

    // start held through an op and asserted with res_ack in DONE.
    opa = 16'd2;
    opb = 16'd3;
    @(posedge clk); #1;
    bus.start = 1'b1;
    sb_q.push_back(model(opa, opb));
    wait_out(ok);
    @(posedge clk); #1;
    bus.res_ack = 1'b1;
    sb_q.push_back(model(opa, opb));
    @(posedge clk); #1;
    bus.res_ack = 1'b0;
    @(negedge clk);
    check("held_start_idle_busy", bus.busy, 0);
    check("held_start_idle_done", bus.done, 0);
    check_quiet("held_start_idle");
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("held_start_ldA", bus.ldA, 1);
    finish_op(1, 16'd3);

    // Reset in the second RUN cycle.
    launch(16'd3, 16'd6, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_quiet("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrun_reset_busy", bus.busy, 0);
    check("midrun_reset_iter", bus.iter_cnt, 0);
    run_op(16'd3, 16'd6, 0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      run_op(CW'($urandom_range(0, 255)), CW'($urandom_range(0, 12)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Controller FSM that sequences the repeated-addition multiplier datapath: the A register, the P register (with clear), the A+P adder, the B down-counter and the B==0 comparator. It loads operands from the shared data bus in two consecutive cycles, then runs P <= P + A once per cycle while the B counter decrements. It signals completion through a done/ack handshake. It also provides abort and an iteration watchdog that flags a stuck loop.

Parameters:
CW, 16, width of the iteration counter; equals the B counter width
MAX_ITER, 16'hFFFF, maximum RUN iterations (ldP pulses) before the watchdog trips; legal range 1..2^CW-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request a multiplication; sampled only in IDLE
abort  input  1  return to IDLE from any state; highest priority after reset
res_ack  input  1  consumer acknowledges done or err
eqz  input  1  comparator output; 1 when the B counter is 0
ldA  output  1  load the A register from data_in (environment drives operand A this cycle)
ldB  output  1  load the B counter from data_in (environment drives operand B this cycle)
clrP  output  1  clear the P register
ldP  output  1  load the P register with the adder output
decB  output  1  decrement the B counter
busy  output  1  1 in LOAD_A, LOAD_B and RUN
done  output  1  result valid in P; held until res_ack
err  output  1  watchdog tripped; held until res_ack
iter_cnt  output  CW  number of ldP pulses in the current or last operation

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, RUN, DONE, ERR. The state register is updated on the rising edge of clk.
- Reset (rst_n=0 at an edge): state=IDLE and iter_cnt=0. All strobes, busy, done and err are 0 while in IDLE. Datapath registers are not reset; clrP in LOAD_B is the only P initialisation.
- Reset or abort mid-operation: next state is IDLE and no strobe is asserted in that cycle. P and B keep whatever partial values they hold.
- IDLE: if start=1, go to LOAD_A; otherwise stay.
- LOAD_A: ldA=1; next state LOAD_B unconditionally.
- LOAD_B: ldB=1 and clrP=1 in the same cycle; iter_cnt cleared to 0; next state RUN.
- RUN is Mealy on eqz, evaluated in priority order:
  - If eqz=1: no strobes; next state DONE.
  - Else if iter_cnt==MAX_ITER: no strobes; next state ERR.
  - Else: ldP=1, decB=1, iter_cnt += 1; stay in RUN.
- Because eqz is checked before the watchdog, B==MAX_ITER completes normally in DONE.
- DONE: done=1. If res_ack=1, go to IDLE (done drops the next cycle).
- ERR: err=1. If res_ack=1, go to IDLE.
- Latency: start seen at edge t gives ldA in cycle t+1, ldB/clrP in t+2, and ldP/decB in t+3 .. t+2+B. The eqz-detect cycle is t+3+B, and done=1 from cycle t+4+B.
  - B=0: done at t+4, P=0.
- Strobe outputs are combinational decodes of state (plus eqz and iter_cnt in RUN). busy, done and err are decodes of the state register only.
- At most one of {ldA, ldB, ldP} is high in any cycle. decB is high only together with ldP, and clrP only together with ldB.
- start outside IDLE is ignored, including start and res_ack in the same DONE cycle: start must be re-presented in IDLE.
- abort together with res_ack resolves to IDLE (same outcome either way).
- iter_cnt holds its final value in DONE, ERR and IDLE until the next LOAD_B. It never wraps, because it is bounded by MAX_ITER.
- Product width and overflow are datapath concerns; the controller does not inspect P.

Decomposition:
- Package mul_seq_pkg:
  - state enum (6 states, 3-bit encoding: IDLE=0, LOAD_A=1, LOAD_B=2, RUN=3, DONE=4, ERR=5)
  - default CW and MAX_ITER constants
- Sub-module iter_wdog: CW-bit counter with clr/inc inputs and a registered-compare output at_max (iter_cnt==MAX_ITER). The FSM instantiates it once.

Test Plan:
- A=5, B=3, start pulse at cycle 0 → ldA@1, ldB+clrP@2, ldP+decB@3,4,5, no strobes@6, done@7; P=15, iter_cnt=3; done held until res_ack, IDLE next cycle.
- A=7, B=0 → ldA@1, ldB@2, no ldP ever, done@4, P=0, iter_cnt=0.
- A=4, B=10, abort asserted during the 2nd RUN cycle → no strobe that cycle, IDLE next, busy=0, done=0, err=0; a new start then completes 4×2=8.
- MAX_ITER=4, B=10 → exactly 4 ldP pulses, ERR entered, err=1, iter_cnt=4 until res_ack; with B=4, done instead (P=4·A).
- start held high through a whole op, with start and res_ack both high in DONE → second op does not begin until start is seen in IDLE the following cycle; no strobes in between.
- rst_n=0 during RUN (A=3, B=6) → IDLE after the edge, all outputs 0, iter_cnt=0; a subsequent op gives 18.
